// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory arbiter: FSM state encoding
// and RISC-V load/store funct3 codes.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DWAIT,
        FWAIT,
        DONE
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/mem_load_align.sv
// Load alignment: picks the byte/half addressed by a[1:0] out of a RAM word
// and sign- or zero-extends it according to funct3.
module mem_load_align
    import mem_arb_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  a,
    input  logic [31:0] word,
    output logic [31:0] result
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign lane_b = word[{a, 3'b000} +: 8];
    assign lane_h = a[1] ? word[31:16] : word[15:0];

    always_comb begin
        result = word;
        case (funct3)
            F3_B:    result = {{24{lane_b[7]}}, lane_b};
            F3_BU:   result = {24'h0, lane_b};
            F3_H:    result = {{16{lane_h[15]}}, lane_h};
            F3_HU:   result = {16'h0, lane_h};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Serialises MEM-stage data access and IF-stage fetch onto one RAM port.
// Optional misaligned-access trapping is enabled with MISALIGN_TRAP_EN.
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int          ADDR_W   = 10,
    parameter logic [31:0] NOP_INSN = 32'h00000033
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_funct3,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_misalign,
    output logic              done,
    output logic              stall,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    state_t      state;
    logic        misalign;
    logic        mis_q;
    logic [3:0]  st_we;
    logic [31:0] st_wdata;
    logic [31:0] ld_data;
    logic        unused;

    assign unused = ^{if_addr[1:0], if_addr[31:ADDR_W+2], d_addr[31:ADDR_W+2]};

`ifdef MISALIGN_TRAP_EN
    always_comb begin
        misalign = 1'b0;
        case (d_funct3)
            F3_B, F3_BU: misalign = 1'b0;
            F3_H, F3_HU: misalign = d_addr[0];
            default:     misalign = |d_addr[1:0];
        endcase
    end
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        st_we    = 4'b1111;
        st_wdata = d_wdata;
        case (d_funct3)
            F3_B, F3_BU: begin
                st_we    = 4'b0001 << d_addr[1:0];
                st_wdata = {4{d_wdata[7:0]}};
            end
            F3_H, F3_HU: begin
                st_we    = 4'b0011 << {d_addr[1], 1'b0};
                st_wdata = {2{d_wdata[15:0]}};
            end
            default: begin
                st_we    = 4'b1111;
                st_wdata = d_wdata;
            end
        endcase
    end

    // Reset gates the port so no access escapes while the FSM is being cleared.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 4'b0000;
        ram_addr  = if_addr[ADDR_W+1:2];
        ram_wdata = st_wdata;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (d_req) begin
                        ram_en   = !misalign;
                        ram_we   = (d_we && !misalign) ? st_we : 4'b0000;
                        ram_addr = d_addr[ADDR_W+1:2];
                    end else if (if_req) begin
                        ram_en = 1'b1;
                    end
                end
                DWAIT:   ram_en = if_req;
                default: ram_en = 1'b0;
            endcase
        end
    end

    assign stall = (state != DONE) && (state != IDLE || if_req || d_req);

    mem_load_align u_align (
        .funct3 (d_funct3),
        .a      (d_addr[1:0]),
        .word   (ram_rdata),
        .result (ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            if_rdata   <= NOP_INSN;
            d_rdata    <= 32'h0;
            done       <= 1'b0;
            d_misalign <= 1'b0;
            mis_q      <= 1'b0;
        end else begin
            done       <= 1'b0;
            d_misalign <= 1'b0;
            case (state)
                IDLE: begin
                    if (d_req) begin
                        mis_q <= misalign;
                        state <= DWAIT;
                    end else if (if_req) begin
                        state <= FWAIT;
                    end
                end
                DWAIT: begin
                    if (mis_q)
                        d_rdata <= 32'h0;
                    else if (!d_we)
                        d_rdata <= ld_data;
                    if (if_req) begin
                        state <= FWAIT;
                    end else begin
                        state      <= DONE;
                        done       <= 1'b1;
                        d_misalign <= mis_q;
                    end
                end
                FWAIT: begin
                    if_rdata   <= ram_rdata;
                    state      <= DONE;
                    done       <= 1'b1;
                    d_misalign <= mis_q;
                end
                default: begin
                    state <= IDLE;
                    mis_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter with a behavioural RAM
// and a scoreboard of expected per-step results.
module tb_unified_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int ADDR_W = 10;

    typedef struct {
        logic [31:0] d;
        logic [31:0] f;
        logic        mis;
        bit          cd;
        bit          cf;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              if_req = 1'b0;
    logic [31:0]       if_addr = 32'h0;
    logic [31:0]       if_rdata;
    logic              d_req = 1'b0;
    logic              d_we = 1'b0;
    logic [2:0]        d_funct3 = 3'b0;
    logic [31:0]       d_addr = 32'h0;
    logic [31:0]       d_wdata = 32'h0;
    logic [31:0]       d_rdata;
    logic              d_misalign;
    logic              done;
    logic              stall;
    logic              ram_en;
    logic [3:0]        ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata = 32'h0;

    logic [31:0] mem [0:(1<<ADDR_W)-1];
    exp_t        sb [$];
    exp_t        sb_e;
    int          checks = 0;
    int          errors = 0;

    unified_mem_arbiter #(.ADDR_W(ADDR_W), .NOP_INSN(32'h00000033)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_rdata   (if_rdata),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_funct3   (d_funct3),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_misalign (d_misalign),
        .done       (done),
        .stall      (stall),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_en) begin
            for (int i = 0; i < 4; i++)
                if (ram_we[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
            ram_rdata <= mem[ram_addr];
        end
    end

    // Scoreboard consumer: every done pulse retires the oldest expected step.
    always @(negedge clk) begin
        if (rst === 1'b0 && done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_unexpected_done got done=1 want no pending step");
            end else begin
                sb_e = sb.pop_front();
                if (sb_e.cd) begin
                    checks++;
                    if (d_rdata !== sb_e.d) begin
                        errors++;
                        $display("FAIL sb_d_rdata got %h want %h", d_rdata, sb_e.d);
                    end
                end
                if (sb_e.cf) begin
                    checks++;
                    if (if_rdata !== sb_e.f) begin
                        errors++;
                        $display("FAIL sb_if_rdata got %h want %h", if_rdata, sb_e.f);
                    end
                end
                checks++;
                if (d_misalign !== sb_e.mis) begin
                    errors++;
                    $display("FAIL sb_misalign got %b want %b", d_misalign, sb_e.mis);
                end
            end
        end
    end

    task automatic start_step(input logic dr, input logic we, input logic [2:0] f3,
                              input logic [31:0] da, input logic [31:0] wd,
                              input logic fr, input logic [31:0] fa,
                              input exp_t e, input bit push);
        @(negedge clk);
        d_req = dr; d_we = we; d_funct3 = f3; d_addr = da; d_wdata = wd;
        if_req = fr; if_addr = fa;
        if (push) sb.push_back(e);
        #1;
    endtask

    task automatic wait_done(output int cyc, output logic [15:0] st);
        cyc = 0;
        st = '0;
        while (cyc < 12) begin
            @(negedge clk);
            cyc++;
            st[cyc] = stall;
            if (done === 1'b1) break;
        end
        d_req = 1'b0; d_we = 1'b0; if_req = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (if_rdata !== 32'h00000033 || d_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata got if=%h d=%h want 00000033/00000000", if_rdata, d_rdata);
        end
        checks++;
        if (done !== 1'b0 || d_misalign !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got done=%b mis=%b stall=%b want 0/0/0", done, d_misalign, stall);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ram_en !== 1'b0 || ram_we !== 4'b0) begin
            errors++;
            $display("FAIL idle_ram got en=%b we=%b want 0/0000", ram_en, ram_we);
        end
    endtask

    task automatic test_fetch;
        int cyc;
        logic [15:0] st;
        logic s0;
        mem[4] = 32'h00500093;
        start_step(0, 0, F3_W, 0, 0, 1, 32'h10, '{32'h0, 32'h00500093, 1'b0, 1'b0, 1'b1}, 1);
        s0 = stall;
        checks++;
        if (ram_en !== 1'b1 || ram_we !== 4'b0 || ram_addr !== 10'd4) begin
            errors++;
            $display("FAIL fetch_issue got en=%b we=%b addr=%0d want 1/0000/4", ram_en, ram_we, ram_addr);
        end
        wait_done(cyc, st);
        checks++;
        if (cyc !== 2) begin
            errors++;
            $display("FAIL fetch_latency got %0d want 2", cyc);
        end
        checks++;
        if ({s0, st[1], st[2]} !== 3'b110) begin
            errors++;
            $display("FAIL fetch_stall got %b want 110", {s0, st[1], st[2]});
        end
    endtask

    task automatic test_store_byte;
        int cyc;
        logic [15:0] st;
        mem[8] = 32'h0;
        start_step(1, 1, F3_B, 32'h23, 32'hAB, 1, 32'h10, '{32'h0, 32'h00500093, 1'b0, 1'b0, 1'b1}, 1);
        checks++;
        if (ram_en !== 1'b1 || ram_we !== 4'b1000 || ram_wdata !== 32'hABABABAB || ram_addr !== 10'd8) begin
            errors++;
            $display("FAIL sb_issue got en=%b we=%b wd=%h addr=%0d want 1/1000/abababab/8",
                     ram_en, ram_we, ram_wdata, ram_addr);
        end
        wait_done(cyc, st);
        checks++;
        if (cyc !== 3) begin
            errors++;
            $display("FAIL sb_latency got %0d want 3", cyc);
        end
        checks++;
        if (mem[8] !== 32'hAB000000) begin
            errors++;
            $display("FAIL sb_mem got %h want ab000000", mem[8]);
        end
    endtask

    task automatic test_loads;
        logic [2:0]  f3s [5] = '{F3_B, F3_BU, F3_H, F3_HU, F3_W};
        logic [31:0] ads [5] = '{32'h20, 32'h20, 32'h22, 32'h22, 32'h20};
        logic [31:0] exs [5] = '{32'hFFFFFF81, 32'h00000081, 32'hFFFF80F0, 32'h000080F0, 32'h80F07F81};
        int cyc;
        logic [15:0] st;
        mem[8] = 32'h80F07F81;
        for (int i = 0; i < 5; i++) begin
            start_step(1, 0, f3s[i], ads[i], 0, 0, 0, '{exs[i], 32'h00500093, 1'b0, 1'b1, 1'b1}, 1);
            wait_done(cyc, st);
            checks++;
            if (cyc !== 2) begin
                errors++;
                $display("FAIL load_latency_%0d got %0d want 2", i, cyc);
            end
        end
        mem[5] = 32'h00A00113;
        start_step(1, 0, F3_HU, 32'h20, 0, 1, 32'h14, '{32'h00007F81, 32'h00A00113, 1'b0, 1'b1, 1'b1}, 1);
        wait_done(cyc, st);
        checks++;
        if (cyc !== 3) begin
            errors++;
            $display("FAIL load_fetch_latency got %0d want 3", cyc);
        end
    endtask

    task automatic test_store_half;
        int cyc;
        logic [15:0] st;
        start_step(1, 1, F3_H, 32'h22, 32'h00001234, 0, 0, '{32'h0, 32'h00A00113, 1'b0, 1'b0, 1'b1}, 1);
        checks++;
        if (ram_we !== 4'b1100 || ram_wdata !== 32'h12341234) begin
            errors++;
            $display("FAIL sh_issue got we=%b wd=%h want 1100/12341234", ram_we, ram_wdata);
        end
        wait_done(cyc, st);
        checks++;
        if (mem[8] !== 32'h12347F81) begin
            errors++;
            $display("FAIL sh_mem got %h want 12347f81", mem[8]);
        end
    endtask

    task automatic test_misalign;
        int cyc;
        logic [15:0] st;
        mem[8] = 32'h80F07F81;
`ifdef MISALIGN_TRAP_EN
        start_step(1, 0, F3_W, 32'h21, 0, 0, 0, '{32'h0, 32'h0, 1'b1, 1'b1, 1'b0}, 1);
        checks++;
        if (ram_en !== 1'b0 || ram_we !== 4'b0) begin
            errors++;
            $display("FAIL mis_issue got en=%b we=%b want 0/0000", ram_en, ram_we);
        end
`else
        start_step(1, 0, F3_W, 32'h21, 0, 0, 0, '{32'h80F07F81, 32'h0, 1'b0, 1'b1, 1'b0}, 1);
        checks++;
        if (ram_en !== 1'b1 || ram_addr !== 10'd8) begin
            errors++;
            $display("FAIL mis_issue got en=%b addr=%0d want 1/8", ram_en, ram_addr);
        end
`endif
        wait_done(cyc, st);
        checks++;
        if (cyc !== 2) begin
            errors++;
            $display("FAIL mis_latency got %0d want 2", cyc);
        end
    endtask

    task automatic test_reset_mid;
        start_step(1, 0, F3_W, 32'h20, 0, 1, 32'h10, '{32'h0, 32'h0, 1'b0, 1'b0, 1'b0}, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (ram_en !== 1'b0 || ram_we !== 4'b0) begin
            errors++;
            $display("FAIL rstmid_ram got en=%b we=%b want 0/0000", ram_en, ram_we);
        end
        @(negedge clk);
        checks++;
        if (dut.state !== IDLE || done !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_state got state=%0d done=%b want 0/0", dut.state, done);
        end
        checks++;
        if (if_rdata !== 32'h00000033 || d_rdata !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_rdata got if=%h d=%h want 00000033/00000000", if_rdata, d_rdata);
        end
        d_req = 1'b0; if_req = 1'b0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_wrap;
        int cyc;
        logic [15:0] st;
        start_step(1, 1, F3_W, 32'h00001004, 32'hCAFEF00D, 0, 0, '{32'h0, 32'h0, 1'b0, 1'b1, 1'b0}, 1);
        checks++;
        if (ram_addr !== 10'd1 || ram_we !== 4'b1111) begin
            errors++;
            $display("FAIL wrap_issue got addr=%0d we=%b want 1/1111", ram_addr, ram_we);
        end
        wait_done(cyc, st);
        checks++;
        if (mem[1] !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL wrap_mem got %h want cafef00d", mem[1]);
        end
    endtask

    initial begin
        test_reset;
        test_fetch;
        test_store_byte;
        test_loads;
        test_store_half;
        test_misalign;
        test_reset_mid;
        test_wrap;
        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d pending want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
